// File: rtl/spi_tx_queue.sv
// Byte FIFO feeding an SPI master, with slave-select sequencing (IDLE/ACTIVE/GAP).
// Optional sticky overflow/underflow flags: define SPI_TXQ_ERR_EN to enable.
module spi_tx_queue #(
    parameter int DEPTH = 8
) (
    input  logic                   sclk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   byte_done,
    output logic [7:0]             data_in,
    output logic                   ss,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf,
    output logic                   unf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        GAP
    } state_t;

    state_t          state;
    logic            gap_cnt;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            pop;
    logic            push;

    // Pops only happen while the master is shifting; a pop frees a slot for a same-cycle write.
    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        pop     = byte_done && !empty && (state == ACTIVE);
        push    = wr_en && (!full || pop);
        data_in = empty ? 8'h00 : mem[rd_ptr];
    end

    // Storage array; writes in the reset cycle are dropped.
    always_ff @(posedge sclk) begin
        if (rst && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge sclk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Slave-select sequencer with a two-cycle deselect gap after the queue drains.
    always_ff @(posedge sclk) begin
        if (!rst) begin
            state   <= IDLE;
            ss      <= 1'b1;
            gap_cnt <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (count != '0) begin
                        state <= ACTIVE;
                        ss    <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (pop && (count == CW'(1)) && !push) begin
                        state   <= GAP;
                        ss      <= 1'b1;
                        gap_cnt <= 1'b0;
                    end
                end
                GAP: begin
                    if (gap_cnt) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ss    <= 1'b1;
                end
            endcase
        end
    end

`ifdef SPI_TXQ_ERR_EN
    // Sticky error flags, cleared only by reset.
    always_ff @(posedge sclk) begin
        if (!rst) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (wr_en && full && !pop) begin
                ovf <= 1'b1;
            end
            if (byte_done && (empty || (state != ACTIVE))) begin
                unf <= 1'b1;
            end
        end
    end
`else
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

endmodule
